// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// mem_access_stage_pkg : shared memory constants (size codes, lane width)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

  localparam logic [1:0]  SIZE_BYTE           = 2'b00;
  localparam logic [1:0]  SIZE_HALF           = 2'b01;
  localparam logic [1:0]  SIZE_WORD           = 2'b10;
  localparam int unsigned UNSIGNED_BIT        = 2;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned TAM_DATA_MEMORY_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// ============================================================================
// mem_access_stage_if : EX/MEM inputs, MEM/WB outputs and debug read port
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_REG_ADDR  = 5
) ();

  logic                    i_step;
  logic                    i_mem_read;
  logic                    i_mem_write;
  logic                    i_reg_write;
  logic                    i_mem_to_reg;
  logic [NB_SIZE_TYPE-1:0] i_size_type;
  logic [NB-1:0]           i_alu_result;
  logic [NB-1:0]           i_store_data;
  logic [NB_REG_ADDR-1:0]  i_rd;
  logic [NB-1:0]           i_debug_address;
  logic                    o_reg_write;
  logic                    o_mem_to_reg;
  logic [NB-1:0]           o_load_data;
  logic [NB-1:0]           o_alu_result;
  logic [NB_REG_ADDR-1:0]  o_rd;
  logic [NB-1:0]           o_debug_data;
  logic                    o_misaligned;

  modport master (
    output i_step, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg,
           i_size_type, i_alu_result, i_store_data, i_rd, i_debug_address,
    input  o_reg_write, o_mem_to_reg, o_load_data, o_alu_result, o_rd,
           o_debug_data, o_misaligned
  );

  modport slave (
    input  i_step, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg,
           i_size_type, i_alu_result, i_store_data, i_rd, i_debug_address,
    output o_reg_write, o_mem_to_reg, o_load_data, o_alu_result, o_rd,
           o_debug_data, o_misaligned
  );

endinterface

`default_nettype wire

// File: rtl/mem_access_stage_load_extender.sv
// ============================================================================
// mem_access_stage_load_extender : lane select plus sign/zero extension
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage_load_extender
  import mem_access_stage_pkg::*;
#(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3
) (
  input  wire logic [NB-1:0]           word_i,
  input  wire logic [1:0]              lane_i,
  input  wire logic [NB_SIZE_TYPE-1:0] size_type_i,
  output logic      [NB-1:0]           data_o
);

  logic [NB-1:0] w_byte_shift;
  logic [NB-1:0] w_half_shift;
  logic          w_signed;

  assign w_byte_shift = word_i >> {lane_i, 3'b000};
  assign w_half_shift = word_i >> {lane_i[1], 4'b0000};
  assign w_signed     = ~size_type_i[UNSIGNED_BIT];

  always_comb begin
    data_o = word_i;
    case (size_type_i[1:0])
      SIZE_BYTE: data_o = {{(NB-8){w_signed & w_byte_shift[7]}}, w_byte_shift[7:0]};
      SIZE_HALF: data_o = {{(NB-16){w_signed & w_half_shift[15]}}, w_half_shift[15:0]};
      default:   data_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : MIPS MEM stage - byte-lane RMW data memory + MEM/WB reg
// Optional misaligned-access trap: define MEM_ACCESS_MISALIGN_TRAP_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int NB              = 32,
  parameter int NB_SIZE_TYPE    = 3,
  parameter int TAM_DATA_MEMORY = TAM_DATA_MEMORY_DEF,
  parameter int NB_REG_ADDR     = 5
) (
  input  wire logic         i_clk,
  input  wire logic         i_reset,
  mem_access_stage_if.slave bus
);

  localparam int ADDR_W   = $clog2(TAM_DATA_MEMORY);
  localparam int NB_LANES = NB / BYTE_W;

  logic [NB-1:0]          mem_q [TAM_DATA_MEMORY];
  logic                   reg_write_q;
  logic                   mem_to_reg_q;
  logic [NB-1:0]          load_data_q;
  logic [NB-1:0]          load_data_d;
  logic [NB-1:0]          alu_result_q;
  logic [NB_REG_ADDR-1:0] rd_q;
  logic                   misaligned_q;

  logic [ADDR_W-1:0]      w_word_idx;
  logic [1:0]             w_lane;
  logic                   w_is_byte;
  logic                   w_is_half;
  logic                   w_misaligned;
  logic                   w_store_en;
  logic [NB_LANES-1:0]    w_byte_en;
  logic [NB-1:0]          w_bit_mask;
  logic [NB-1:0]          w_store_aligned;
  logic [NB-1:0]          w_rd_word;
  logic [NB-1:0]          w_merged;
  logic [NB-1:0]          w_load_ext;
  logic                   w_unused;

  assign w_word_idx = bus.i_alu_result[ADDR_W+1:2];
  assign w_lane     = bus.i_alu_result[1:0];
  assign w_is_byte  = (bus.i_size_type[1:0] == SIZE_BYTE);
  assign w_is_half  = (bus.i_size_type[1:0] == SIZE_HALF);
  assign w_rd_word  = mem_q[w_word_idx];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign w_misaligned = (bus.i_mem_read | bus.i_mem_write) &
                        ((w_is_half & w_lane[0]) |
                         (~w_is_byte & ~w_is_half & (w_lane != 2'b00)));
`else
  assign w_misaligned = 1'b0;
`endif

  // Replicate the store data into every lane; the byte enables pick the lanes kept.
  always_comb begin
    w_byte_en       = '1;
    w_store_aligned = bus.i_store_data;
    if (w_is_byte) begin
      w_byte_en         = '0;
      w_byte_en[w_lane] = 1'b1;
      w_store_aligned   = {NB_LANES{bus.i_store_data[7:0]}};
    end else if (w_is_half) begin
      w_byte_en       = w_lane[1] ? 4'b1100 : 4'b0011;
      w_store_aligned = {(NB/16){bus.i_store_data[15:0]}};
    end
  end

  always_comb begin
    w_bit_mask = '0;
    for (int b = 0; b < NB_LANES; b++) begin
      w_bit_mask[b*BYTE_W +: BYTE_W] = {BYTE_W{w_byte_en[b]}};
    end
  end

  assign w_merged   = (w_rd_word & ~w_bit_mask) | (w_store_aligned & w_bit_mask);
  assign w_store_en = bus.i_step & bus.i_mem_write & ~w_misaligned;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < TAM_DATA_MEMORY; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_store_en) begin
      mem_q[w_word_idx] <= w_merged;
    end
  end

  mem_access_stage_load_extender #(
    .NB           (NB),
    .NB_SIZE_TYPE (NB_SIZE_TYPE)
  ) u_load_extender (
    .word_i      (w_rd_word),
    .lane_i      (w_lane),
    .size_type_i (bus.i_size_type),
    .data_o      (w_load_ext)
  );

  // Load data is read before this edge's store lands, so read+write returns old data.
  assign load_data_d = (bus.i_mem_read & ~w_misaligned) ? w_load_ext : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_data_q  <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
    end else if (bus.i_step) begin
      reg_write_q  <= bus.i_reg_write & ~w_misaligned;
      mem_to_reg_q <= bus.i_mem_to_reg;
      load_data_q  <= load_data_d;
      alu_result_q <= bus.i_alu_result;
      rd_q         <= bus.i_rd;
      misaligned_q <= w_misaligned;
    end
  end

  assign bus.o_reg_write  = reg_write_q;
  assign bus.o_mem_to_reg = mem_to_reg_q;
  assign bus.o_load_data  = load_data_q;
  assign bus.o_alu_result = alu_result_q;
  assign bus.o_rd         = rd_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_debug_data = mem_q[bus.i_debug_address[ADDR_W-1:0]];

  assign w_unused = ^{bus.i_alu_result[NB-1:ADDR_W+2], bus.i_debug_address[NB-1:ADDR_W]};

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : vector table + scoreboard bench for mem_access_stage
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_stage;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int NV = 21;

  typedef struct packed {
    logic        step;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_ld;
    logic        exp_mis;
  } vec_t;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] ld;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mis;
  } out_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs [NV];
  out_t sb [$];
  out_t prev;
  out_t want;
  logic [7:0] mdl [64];

  mem_access_stage_if #(.NB(32), .NB_SIZE_TYPE(3), .NB_REG_ADDR(5)) bus ();

  mem_access_stage dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic r, input logic w, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] el, input logic em);
    vec_t v;
    v.step = st; v.rd_en = r; v.wr_en = w; v.size = sz; v.addr = a;
    v.wdata = wd; v.exp_ld = el; v.exp_mis = em;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.rw  = bus.o_reg_write;
    o.m2r = bus.o_mem_to_reg;
    o.ld  = bus.o_load_data;
    o.alu = bus.o_alu_result;
    o.rd  = bus.o_rd;
    o.mis = bus.o_misaligned;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int idx);
    bus.i_step       = v.step;
    bus.i_mem_read   = v.rd_en;
    bus.i_mem_write  = v.wr_en;
    bus.i_reg_write  = 1'b1;
    bus.i_mem_to_reg = v.rd_en;
    bus.i_size_type  = v.size;
    bus.i_alu_result = v.addr;
    bus.i_store_data = v.wdata;
    bus.i_rd         = idx[4:0];
  endtask

  task automatic model_store(input vec_t v);
    logic [5:0] a;
    a = v.addr[5:0];
    case (v.size[1:0])
      2'b00: mdl[a] = v.wdata[7:0];
      2'b01: begin
        mdl[{a[5:1], 1'b0}] = v.wdata[7:0];
        mdl[{a[5:1], 1'b1}] = v.wdata[15:8];
      end
      default: begin
        mdl[{a[5:2], 2'b00}] = v.wdata[7:0];
        mdl[{a[5:2], 2'b01}] = v.wdata[15:8];
        mdl[{a[5:2], 2'b10}] = v.wdata[23:16];
        mdl[{a[5:2], 2'b11}] = v.wdata[31:24];
      end
    endcase
  endtask

  function automatic logic [31:0] model_word(input int k);
    return {mdl[4*k+3], mdl[4*k+2], mdl[4*k+1], mdl[4*k]};
  endfunction

  task automatic debug_read(input int k, output logic [31:0] d);
    bus.i_debug_address = k;
    #1;
    d = bus.o_debug_data;
  endtask

  initial begin
    logic [31:0] d;
    out_t        got;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;

    vecs[0]  = mk(1, 0, 1, 3'b010, 32'd4,  32'h8081F27F, 32'h0,        1'b0);
    vecs[1]  = mk(1, 1, 0, 3'b000, 32'd4,  32'h0,        32'h0000007F, 1'b0);
    vecs[2]  = mk(1, 1, 0, 3'b100, 32'd4,  32'h0,        32'h0000007F, 1'b0);
    vecs[3]  = mk(1, 1, 0, 3'b000, 32'd5,  32'h0,        32'hFFFFFFF2, 1'b0);
    vecs[4]  = mk(1, 1, 0, 3'b100, 32'd7,  32'h0,        32'h00000080, 1'b0);
    vecs[5]  = mk(1, 0, 1, 3'b001, 32'd6,  32'h1234BEEF, 32'h0,        1'b0);
    vecs[6]  = mk(1, 1, 0, 3'b001, 32'd6,  32'h0,        32'hFFFFBEEF, 1'b0);
    vecs[7]  = mk(1, 1, 0, 3'b101, 32'd6,  32'h0,        32'h0000BEEF, 1'b0);
    vecs[8]  = mk(1, 1, 0, 3'b010, 32'd4,  32'h0,        32'hBEEFF27F, 1'b0);
    vecs[9]  = mk(1, 0, 1, 3'b000, 32'd65, 32'hAAAAAA12, 32'h0,        1'b0);
    vecs[10] = mk(0, 0, 1, 3'b000, 32'd65, 32'h000000FF, 32'h0,        1'b0);
    vecs[11] = mk(1, 1, 0, 3'b100, 32'd65, 32'h0,        32'h00000012, 1'b0);
    vecs[12] = mk(1, 0, 1, 3'b010, 32'd8,  32'hCAFEBABE, 32'h0,        1'b0);
    vecs[13] = mk(1, 1, 0, 3'b010, 32'd8,  32'h0,        32'hCAFEBABE, 1'b0);
    vecs[14] = mk(1, 1, 0, 3'b110, 32'd8,  32'h0,        32'hCAFEBABE, 1'b0);
    vecs[15] = mk(1, 1, 1, 3'b010, 32'd8,  32'h11223344, 32'hCAFEBABE, 1'b0);
    vecs[16] = mk(1, 1, 0, 3'b010, 32'd8,  32'h0,        32'h11223344, 1'b0);
    vecs[17] = mk(1, 0, 1, 3'b010, 32'd9,  32'hDEADBEEF, 32'h0,        TRAP);
    vecs[18] = mk(1, 1, 0, 3'b010, 32'd8,  32'h0, TRAP ? 32'h11223344 : 32'hDEADBEEF, 1'b0);
    vecs[19] = mk(1, 1, 0, 3'b000, 32'd7,  32'h0,        32'hFFFFFFBE, 1'b0);
    vecs[20] = mk(1, 1, 0, 3'b001, 32'd5,  32'h0, TRAP ? 32'h0 : 32'hFFFFF27F, TRAP);

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0), 0);
    bus.i_debug_address = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", sample(), '0);
    for (int k = 0; k < 16; k++) begin
      debug_read(k, d);
      chk($sformatf("reset_debug_word%0d", k), d, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    prev = '0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i], i);
      if (vecs[i].step) begin
        prev.rw  = ~vecs[i].exp_mis;
        prev.m2r = vecs[i].rd_en;
        prev.ld  = vecs[i].exp_ld;
        prev.alu = vecs[i].addr;
        prev.rd  = i[4:0];
        prev.mis = vecs[i].exp_mis;
        if (vecs[i].wr_en && !vecs[i].exp_mis) model_store(vecs[i]);
      end
      sb.push_back(prev);
      @(posedge clk);
      #1;
      got  = sample();
      want = sb.pop_front();
      chk($sformatf("vec%0d", i), got, want);
    end

    @(negedge clk);
    bus.i_step = 1'b0;
    debug_read(0, d);
    chk("debug_word0_sb_wrap", d, 32'h00001200);
    debug_read(1, d);
    chk("debug_word1_sh", d, 32'hBEEFF27F);
    debug_read(2, d);
    chk("debug_word2_sw9", d, TRAP ? 32'h11223344 : 32'hDEADBEEF);
    for (int k = 0; k < 16; k++) begin
      debug_read(k, d);
      chk($sformatf("model_word%0d", k), d, model_word(k));
    end

    // Reset asserted between edges with a store pending: store lost, outputs clear at once.
    @(negedge clk);
    drive(mk(1, 1, 1, 3'b010, 32'd12, 32'h55555555, 32'h0, 1'b0), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", sample(), '0);
    @(posedge clk);
    #1;
    debug_read(3, d);
    chk("reset_store_lost", d, 32'h0);
    debug_read(1, d);
    chk("reset_clears_mem", d, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    drive(mk(1, 0, 1, 3'b010, 32'd12, 32'h0BADF00D, 32'h0, 1'b0), 4);
    @(negedge clk);
    drive(mk(1, 1, 0, 3'b001, 32'd14, 32'h0, 32'h0, 1'b0), 5);
    @(posedge clk);
    #1;
    chk("post_reset_lh", bus.o_load_data, 32'h00000BAD);
    chk("post_reset_rd", bus.o_rd, 5'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and write-back.
- Owns the word-organised data memory.
- Executes SB/SH/SW as byte-lane read-modify-write stores.
- Executes LB/LBU/LH/LHU/LW/LWU with sign or zero extension.
- Registers the MEM/WB bundle.
- Provides a debug read port for the pipeline top-level o_mips_data_memory output.

Parameters:
NB, 32, datapath width (bits)
NB_SIZE_TYPE, 3, width of access-size/sign code
TAM_DATA_MEMORY, 16, data memory depth in NB-bit words (power of 2)
NB_REG_ADDR, 5, register index width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_step  in  1  pipeline advance enable; stage holds when 0
i_mem_read  in  1  load in MEM this cycle
i_mem_write  in  1  store in MEM this cycle
i_reg_write  in  1  instruction writes GPR
i_mem_to_reg  in  1  WB selects load data (1) or ALU result (0)
i_size_type  in  NB_SIZE_TYPE  [1:0] 00 byte, 01 half, 10 word; [2] 1 = unsigned
i_alu_result  in  NB  effective byte address / ALU result
i_store_data  in  NB  rt value; low bytes used for SB/SH
i_rd  in  NB_REG_ADDR  destination register
i_debug_address  in  NB  word index for debug read
o_reg_write  out  1  registered i_reg_write
o_mem_to_reg  out  1  registered i_mem_to_reg
o_load_data  out  NB  registered extended load data
o_alu_result  out  NB  registered ALU result
o_rd  out  NB_REG_ADDR  registered destination
o_debug_data  out  NB  combinational memory[i_debug_address mod TAM_DATA_MEMORY]
o_misaligned  out  1  registered misalignment flag (see Optional Feature)

Behaviour:
- Reset (i_reset=0, asynchronous): all registered outputs = 0; every memory word = 0.
- Word index = i_alu_result[log2(TAM)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*TAM bytes.
- Byte lane = i_alu_result[1:0], little-endian: lane k occupies bits [8k+7:8k]. Halfword lane is selected by addr[1].
- Store, on the rising edge with i_step=1 and i_mem_write=1:
  - SB updates only the addressed byte with i_store_data[7:0].
  - SH updates only the addressed half with i_store_data[15:0].
  - SW replaces the whole word.
  - Untouched bytes are preserved.
- Load is a combinational read of the current memory word, then lane select, then extension:
  - Signed (size_type[2]=0) replicates the lane MSB.
  - Unsigned zero-fills.
  - Word size ignores the sign bit; LW and LWU are identical at 32 bits.
- The MEM/WB register captures on the rising edge when i_step=1 and holds when i_step=0. Latency is 1 cycle from EX/MEM valid to outputs.
- When i_mem_read=0, o_load_data captures 0.
- Store then load to the same word in consecutive steps: the load sees the new data, because the memory write precedes the next read.
- i_mem_read and i_mem_write both 1: the store is performed and load data reflects the pre-store contents.
- i_step=0: no memory write and no register update, regardless of control inputs.
- Reset asserted mid-operation clears everything immediately. A store on that edge is lost.

Optional Feature:
Macro MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned. For a misaligned access:
  - The store is suppressed.
  - Load data captures 0.
  - o_reg_write captures 0.
  - o_misaligned captures 1 for that step.
- Undefined: misaligned low address bits are silently ignored (half uses addr[1], word uses the full word), and o_misaligned is tied to 0.

Decomposition:
- Shared package/header memory_constants: size codes (SIZE_BYTE, SIZE_HALF, SIZE_WORD), unsigned bit position, byte-lane width, TAM_DATA_MEMORY default.
- One sub-module, load_extender: combinational lane select plus sign/zero extension of the memory word.
- Store-mask generation and the memory array stay in mem_access_stage.

Test Plan:
- Reset, then debug-read words 0..15 -> all 0; all outputs 0.
- SW 0x8081F27F @ addr 4; then LB @ 4, LBU @ 4, LB @ 5, LBU @ 7 -> o_load_data 0x0000007F, 0x0000007F, 0xFFFFFFF2, 0x00000080.
- SH 0xBEEF @ addr 6 over that word -> debug word 1 = 0xBEEFF27F. LH @ 6 -> 0xFFFFBEEF; LHU @ 6 -> 0x0000BEEF.
- SB 0x12 @ addr 65 (wraps to word 0) -> debug word 0 = 0x00001200. Hold i_step=0 with a store of 0xFF to addr 65 -> no change.
- Back-to-back SW 0xCAFEBABE @ 8 then LW @ 8 on the next step -> 0xCAFEBABE. LWU @ 8 -> identical value.
- With MEM_ACCESS_MISALIGN_TRAP_EN: SW @ addr 9 -> memory unchanged, o_misaligned=1, o_reg_write=0. Without the macro: same store writes word 2.
